// File: rtl/bike_motion_ctrl_pkg.sv
// Shared types for the Tron bike motion engine: directions, game-state codes,
// per-bike FSM states and the reversal helper.
package bike_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_SPAWN = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2
    } bike_st_t;

    localparam logic [2:0] GS_SPAWN = 3'b001;
    localparam logic [2:0] GS_RUN   = 3'b010;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      opposite = DOWN;
            DOWN:    opposite = UP;
            LEFT:    opposite = RIGHT;
            default: opposite = LEFT;
        endcase
    endfunction

endpackage

// File: rtl/bike_motion_ctrl_if.sv
// Bus between the game logic / keyboard decoder (master) and the motion engine
// (slave); outputs feed the trail RAM and sprite renderer.
interface bike_motion_ctrl_if #(
    parameter int NUM_BIKES = 2,
    parameter int POS_W     = 10,
    parameter int CELL_LOG2 = 2
);
    logic                                   frame_clk;
    logic [2:0]                             Game_State;
    logic [NUM_BIKES-1:0]                   turn_req;
    logic [2*NUM_BIKES-1:0]                 turn_dir;
    logic [POS_W*NUM_BIKES-1:0]             bike_x_real;
    logic [POS_W*NUM_BIKES-1:0]             bike_y_real;
    logic [(POS_W-CELL_LOG2)*NUM_BIKES-1:0] bike_x_cell;
    logic [(POS_W-CELL_LOG2)*NUM_BIKES-1:0] bike_y_cell;
    logic [2*NUM_BIKES-1:0]                 bike_dir;
    logic [NUM_BIKES-1:0]                   crashed;
    logic                                   step_pulse;

    modport master (
        output frame_clk, Game_State, turn_req, turn_dir,
        input  bike_x_real, bike_y_real, bike_x_cell, bike_y_cell,
               bike_dir, crashed, step_pulse
    );

    modport slave (
        input  frame_clk, Game_State, turn_req, turn_dir,
        output bike_x_real, bike_y_real, bike_x_cell, bike_y_cell,
               bike_dir, crashed, step_pulse
    );
endinterface

// File: rtl/bike_motion_ctrl_channel.sv
// One bike: spawn/run/crash FSM, one-entry turn buffer, position and direction
// registers, next-position arithmetic and wall check.
module bike_channel
    import bike_pkg::*;
#(
    parameter int   POS_W     = 10,
    parameter int   CELL_LOG2 = 2,
    parameter int   STEP      = 1,
    parameter int   X_MIN     = 14,
    parameter int   X_MAX     = 462,
    parameter int   Y_MIN     = 14,
    parameter int   Y_MAX     = 462,
    parameter int   SPAWN_X   = 76,
    parameter int   SPAWN_Y   = 240,
    parameter dir_t SPAWN_DIR = RIGHT
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       i_spawn,
    input  logic                       i_run,
    input  logic                       i_tick,
    input  logic                       i_turn_req,
    input  dir_t                       i_turn_dir,
    input  logic                       i_headon,
    output logic [POS_W-1:0]           o_x,
    output logic [POS_W-1:0]           o_y,
    output dir_t                       o_dir,
    output logic                       o_crashed,
    output logic                       o_moving,
    output logic [POS_W-CELL_LOG2-1:0] o_nx_cell,
    output logic [POS_W-CELL_LOG2-1:0] o_ny_cell
);
    localparam logic signed [POS_W:0] STEP_S  = (POS_W+1)'(STEP);
    localparam logic signed [POS_W:0] X_MIN_S = (POS_W+1)'(X_MIN);
    localparam logic signed [POS_W:0] X_MAX_S = (POS_W+1)'(X_MAX);
    localparam logic signed [POS_W:0] Y_MIN_S = (POS_W+1)'(Y_MIN);
    localparam logic signed [POS_W:0] Y_MAX_S = (POS_W+1)'(Y_MAX);

    logic [POS_W-1:0] r_x, r_y;
    dir_t             r_dir, r_pend;
    logic             r_pend_v, r_crash;
    bike_st_t         r_state;

    logic                w_aligned, w_use_pend, w_act, w_wall, w_req_ok;
    dir_t                w_dir;
    logic signed [POS_W:0] w_nx, w_ny;

    assign w_aligned  = (r_x[CELL_LOG2-1:0] == '0) && (r_y[CELL_LOG2-1:0] == '0);
    assign w_use_pend = r_pend_v && w_aligned;
    assign w_dir      = w_use_pend ? r_pend : r_dir;
    assign w_act      = i_tick && i_run && (r_state == ST_RUN);

    // One extra sign bit so a step below zero shows up as negative, not as a wrap.
    always_comb begin
        w_nx = $signed({1'b0, r_x});
        w_ny = $signed({1'b0, r_y});
        case (w_dir)
            UP:      w_ny = w_ny - STEP_S;
            DOWN:    w_ny = w_ny + STEP_S;
            LEFT:    w_nx = w_nx - STEP_S;
            default: w_nx = w_nx + STEP_S;
        endcase
    end

    assign w_wall   = (w_nx < X_MIN_S) || (w_nx > X_MAX_S) ||
                      (w_ny < Y_MIN_S) || (w_ny > Y_MAX_S);
    assign w_req_ok = i_turn_req && (r_state != ST_CRASH) &&
                      (i_turn_dir != r_dir) && (i_turn_dir != opposite(r_dir));

    always_ff @(posedge Clk) begin
        if (Reset || i_spawn) begin
            r_x      <= POS_W'(SPAWN_X);
            r_y      <= POS_W'(SPAWN_Y);
            r_dir    <= SPAWN_DIR;
            r_pend   <= UP;
            r_pend_v <= 1'b0;
            r_crash  <= 1'b0;
            r_state  <= ST_SPAWN;
        end else begin
            if (r_state == ST_SPAWN && i_run)
                r_state <= ST_RUN;
            if (w_act) begin
                if (w_wall) begin
                    r_crash <= 1'b1;
                    r_state <= ST_CRASH;
                end else begin
                    r_x   <= w_nx[POS_W-1:0];
                    r_y   <= w_ny[POS_W-1:0];
                    r_dir <= w_dir;
                    if (w_use_pend)
                        r_pend_v <= 1'b0;
                    if (i_headon) begin
                        r_crash <= 1'b1;
                        r_state <= ST_CRASH;
                    end
                end
            end
            // Same-cycle request lands after the tick consumed the old entry.
            if (w_req_ok) begin
                r_pend   <= i_turn_dir;
                r_pend_v <= 1'b1;
            end
        end
    end

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_dir     = r_dir;
    assign o_crashed = r_crash;
    assign o_moving  = w_act && !w_wall;
    assign o_nx_cell = w_nx[POS_W-1:CELL_LOG2];
    assign o_ny_cell = w_ny[POS_W-1:CELL_LOG2];

endmodule

// File: rtl/bike_motion_ctrl.sv
// N-bike motion engine top: frame strobe edge detect, step pulse, bike channels
// and output packing. Define BIKE_HEADON_EN to crash bikes entering the same cell.
module bike_motion_ctrl
    import bike_pkg::*;
#(
    parameter int NUM_BIKES = 2,
    parameter int POS_W     = 10,
    parameter int CELL_LOG2 = 2,
    parameter int STEP      = 1,
    parameter int X_MIN     = 14,
    parameter int X_MAX     = 462,
    parameter int Y_MIN     = 14,
    parameter int Y_MAX     = 462,
    parameter int SPAWN_X0  = 76,
    parameter int SPAWN_DX  = 324,
    parameter int SPAWN_Y   = 240
) (
    input  logic              Clk,
    input  logic              Reset,
    bike_motion_ctrl_if.slave bus
);
    localparam int CW = POS_W - CELL_LOG2;

    logic r_frame_d, r_tick, r_step;
    logic w_spawn, w_run;

    logic [NUM_BIKES-1:0][POS_W-1:0] w_x, w_y;
    logic [NUM_BIKES-1:0][CW-1:0]    w_xc, w_yc, w_ncx, w_ncy;
    logic [NUM_BIKES-1:0][1:0]       w_dir;
    logic [NUM_BIKES-1:0]            w_crash, w_moving, w_headon;

    assign w_spawn = (bus.Game_State == GS_SPAWN);
    assign w_run   = (bus.Game_State == GS_RUN);

    // Positions update on the edge where r_tick is high, two Clk after the rise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_d <= 1'b0;
            r_tick    <= 1'b0;
            r_step    <= 1'b0;
        end else begin
            r_frame_d <= bus.frame_clk;
            r_tick    <= bus.frame_clk & ~r_frame_d;
            r_step    <= r_tick & w_run;
        end
    end

    for (genvar i = 0; i < NUM_BIKES; i++) begin : g_bike
        bike_channel #(
            .POS_W     (POS_W),
            .CELL_LOG2 (CELL_LOG2),
            .STEP      (STEP),
            .X_MIN     (X_MIN),
            .X_MAX     (X_MAX),
            .Y_MIN     (Y_MIN),
            .Y_MAX     (Y_MAX),
            .SPAWN_X   (SPAWN_X0 + i * SPAWN_DX),
            .SPAWN_Y   (SPAWN_Y),
            .SPAWN_DIR ((i % 2 == 0) ? RIGHT : LEFT)
        ) u_ch (
            .Clk        (Clk),
            .Reset      (Reset),
            .i_spawn    (w_spawn),
            .i_run      (w_run),
            .i_tick     (r_tick),
            .i_turn_req (bus.turn_req[i]),
            .i_turn_dir (dir_t'(bus.turn_dir[2*i +: 2])),
            .i_headon   (w_headon[i]),
            .o_x        (w_x[i]),
            .o_y        (w_y[i]),
            .o_dir      (w_dir[i]),
            .o_crashed  (w_crash[i]),
            .o_moving   (w_moving[i]),
            .o_nx_cell  (w_ncx[i]),
            .o_ny_cell  (w_ncy[i])
        );
        assign w_xc[i] = w_x[i][POS_W-1:CELL_LOG2];
        assign w_yc[i] = w_y[i][POS_W-1:CELL_LOG2];
    end

`ifdef BIKE_HEADON_EN
    always_comb begin
        w_headon = '0;
        for (int a = 0; a < NUM_BIKES; a++)
            for (int b = 0; b < NUM_BIKES; b++)
                if (a != b && w_moving[a] && w_moving[b] &&
                    w_ncx[a] == w_ncx[b] && w_ncy[a] == w_ncy[b])
                    w_headon[a] = 1'b1;
    end
`else
    logic w_unused_headon;
    assign w_unused_headon = ^{w_moving, w_ncx, w_ncy};
    assign w_headon        = '0;
`endif

    assign bus.bike_x_real = w_x;
    assign bus.bike_y_real = w_y;
    assign bus.bike_x_cell = w_xc;
    assign bus.bike_y_cell = w_yc;
    assign bus.bike_dir    = w_dir;
    assign bus.crashed     = w_crash;
    assign bus.step_pulse  = r_step;

endmodule

// File: tb/tb_bike_motion_ctrl.sv
// Directed bench for bike_motion_ctrl: a small reference model feeds a
// scoreboard of expected states popped on each step_pulse.
module tb_bike_motion_ctrl;
    import bike_pkg::*;

    localparam int NB = 2;
    localparam int PW = 10;
    localparam int CL = 2;
`ifdef BIKE_HEADON_EN
    localparam bit HO = 1'b1;
`else
    localparam bit HO = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    always #10 Clk = ~Clk;

    bike_motion_ctrl_if #(.NUM_BIKES(NB), .POS_W(PW), .CELL_LOG2(CL)) bus ();
    bike_motion_ctrl #(.NUM_BIKES(NB), .POS_W(PW), .CELL_LOG2(CL)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        int x0, y0, d0, c0;
        int x1, y1, d1, c1;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    int mx[NB], my[NB], md[NB], mp[NB];
    bit mpv[NB], mc[NB];

    function automatic void m_spawn();
        for (int i = 0; i < NB; i++) begin
            mx[i] = 76 + i * 324; my[i] = 240;
            md[i] = (i % 2 == 0) ? 3 : 2;
            mpv[i] = 1'b0; mc[i] = 1'b0; mp[i] = 0;
        end
    endfunction

    function automatic void m_turn(int i, int d);
        if (!mc[i] && d != md[i] && d != (md[i] ^ 1)) begin
            mp[i] = d; mpv[i] = 1'b1;
        end
    endfunction

    function automatic void m_tick();
        int nx[NB], ny[NB], nd[NB];
        bit mv[NB], ap[NB];
        for (int i = 0; i < NB; i++) begin
            mv[i] = 1'b0; ap[i] = 1'b0;
            nx[i] = mx[i]; ny[i] = my[i]; nd[i] = md[i];
            if (!mc[i]) begin
                ap[i] = mpv[i] && (mx[i] % 4 == 0) && (my[i] % 4 == 0);
                if (ap[i]) nd[i] = mp[i];
                case (nd[i])
                    0: ny[i] = ny[i] - 1;
                    1: ny[i] = ny[i] + 1;
                    2: nx[i] = nx[i] - 1;
                    default: nx[i] = nx[i] + 1;
                endcase
                if (nx[i] < 14 || nx[i] > 462 || ny[i] < 14 || ny[i] > 462) mc[i] = 1'b1;
                else mv[i] = 1'b1;
            end
        end
        if (HO && mv[0] && mv[1] && (nx[0] / 4 == nx[1] / 4) && (ny[0] / 4 == ny[1] / 4)) begin
            mc[0] = 1'b1; mc[1] = 1'b1;
        end
        for (int i = 0; i < NB; i++)
            if (mv[i]) begin
                mx[i] = nx[i]; my[i] = ny[i]; md[i] = nd[i];
                if (ap[i]) mpv[i] = 1'b0;
            end
    endfunction

    function automatic exp_t m_snap();
        exp_t e;
        e.x0 = mx[0]; e.y0 = my[0]; e.d0 = md[0]; e.c0 = int'(mc[0]);
        e.x1 = mx[1]; e.y1 = my[1]; e.d1 = md[1]; e.c1 = int'(mc[1]);
        return e;
    endfunction

    function automatic logic [31:0] gx(int i); return 32'(bus.bike_x_real[PW*i +: PW]); endfunction
    function automatic logic [31:0] gy(int i); return 32'(bus.bike_y_real[PW*i +: PW]); endfunction
    function automatic logic [31:0] gd(int i); return 32'(bus.bike_dir[2*i +: 2]); endfunction
    function automatic logic [31:0] gc(int i); return 32'(bus.crashed[i]); endfunction
    function automatic logic [31:0] gxc(int i); return 32'(bus.bike_x_cell[(PW-CL)*i +: (PW-CL)]); endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cmp(string tag, exp_t e);
        chk({tag, "_x0"}, gx(0), e.x0);
        chk({tag, "_y0"}, gy(0), e.y0);
        chk({tag, "_d0"}, gd(0), e.d0);
        chk({tag, "_c0"}, gc(0), e.c0);
        chk({tag, "_xc0"}, gxc(0), e.x0 / 4);
        chk({tag, "_x1"}, gx(1), e.x1);
        chk({tag, "_y1"}, gy(1), e.y1);
        chk({tag, "_d1"}, gd(1), e.d1);
        chk({tag, "_c1"}, gc(1), e.c1);
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic turn(int i, int d);
        bus.turn_req[i] = 1'b1;
        bus.turn_dir[2*i +: 2] = 2'(d);
        m_turn(i, d);
        cyc(1);
        bus.turn_req = '0;
    endtask

    task automatic tick_run(string tag);
        int k = 0;
        m_tick();
        sb.push_back(m_snap());
        bus.frame_clk = 1'b1;
        do begin
            cyc(1);
            k++;
        end while (!bus.step_pulse && k < 6);
        chk({tag, "_step"}, 32'(bus.step_pulse), 1);
        chk({tag, "_lat"}, k, 2);
        cmp(tag, sb.pop_front());
        bus.frame_clk = 1'b0;
        cyc(1);
        chk({tag, "_step1"}, 32'(bus.step_pulse), 0);
        cyc(1);
    endtask

    initial begin
        bit seen;
        bus.frame_clk = 1'b0; bus.Game_State = 3'b000;
        bus.turn_req = '0; bus.turn_dir = '0;
        Reset = 1'b1;
        cyc(3);
        m_spawn();
        cmp("rst", m_snap());
        chk("rst_x0", gx(0), 76);
        chk("rst_x1", gx(1), 400);
        chk("rst_d0", gd(0), 3);
        chk("rst_d1", gd(1), 2);
        chk("rst_step", 32'(bus.step_pulse), 0);
        Reset = 1'b0;
        bus.Game_State = GS_RUN;
        cyc(2);

        // first move
        tick_run("t1");
        chk("t1_x0", gx(0), 77);
        chk("t1_x1", gx(1), 399);

        // buffered turn waits for alignment
        turn(0, 0);
        for (int i = 0; i < 3; i++) tick_run("t2a");
        chk("t2_x0_80", gx(0), 80);
        chk("t2_d0_right", gd(0), 3);
        tick_run("t2b");
        chk("t2_x0", gx(0), 80);
        chk("t2_y0", gy(0), 239);
        chk("t2_d0_up", gd(0), 0);

        // reversal dropped, later valid turn applied
        bus.Game_State = GS_SPAWN; cyc(2);
        m_spawn();
        cmp("spawn", m_snap());
        bus.Game_State = GS_RUN; cyc(2);
        tick_run("t3a");
        turn(0, 2);
        tick_run("t3b");
        chk("t3_x0", gx(0), 78);
        chk("t3_d0_right", gd(0), 3);
        tick_run("t3c");
        tick_run("t3d");
        turn(0, 1);
        tick_run("t3e");
        chk("t3_x0_80", gx(0), 80);
        chk("t3_y0_241", gy(0), 241);
        chk("t3_d0_down", gd(0), 1);

        // reset mid-run clears pending
        turn(0, 2);
        Reset = 1'b1; cyc(1); Reset = 1'b0;
        m_spawn();
        cmp("mrst", m_snap());
        cyc(1);
        for (int i = 0; i < 5; i++) tick_run("t6a");
        chk("t6_x0_81", gx(0), 81);
        chk("t6_d0_right", gd(0), 3);
        for (int i = 5; i < 50; i++) tick_run("t6b");
        bus.Game_State = GS_SPAWN; cyc(1);
        m_spawn();
        bus.Game_State = GS_RUN; cyc(1);
        cmp("t6_spawn", m_snap());
        chk("t6_spawn_x0", gx(0), 76);

        // hold state ignores ticks
        bus.Game_State = 3'b000; cyc(1);
        bus.frame_clk = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (bus.step_pulse) seen = 1'b1;
        end
        bus.frame_clk = 1'b0; cyc(2);
        chk("hold_step", 32'(seen), 0);
        cmp("hold", m_snap());
        bus.Game_State = GS_RUN; cyc(2);

        // long run into the walls; the bikes cross near tick 161
        for (int i = 1; i <= 387; i++) begin
            tick_run("t4");
            if (i == 161) begin
                chk("t5_x0", gx(0), 237);
                chk("t5_x1", gx(1), 239);
                chk("t5_c0", gc(0), HO ? 1 : 0);
                chk("t5_c1", gc(1), HO ? 1 : 0);
            end
            if (i == 386) chk("t4_x0_386", gx(0), HO ? 237 : 462);
        end
        chk("t4_x0", gx(0), HO ? 237 : 462);
        chk("t4_c0", gc(0), 1);
        chk("t4_x1", gx(1), HO ? 239 : 14);
        turn(0, 0);
        tick_run("t4post");
        chk("t4post_x0", gx(0), HO ? 237 : 462);
        chk("t4post_d0", gd(0), 3);
        chk("t4post_c0", gc(0), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bike_motion_ctrl.md
Name: bike_motion_ctrl

Overview:
Parametrised N-bike motion engine for the Tron arena. It is the successor to the two-bike hard-coded movement logic.
- Per-bike position/direction registers.
- One-entry buffered turn requests, applied only on grid alignment, with reversal rejection.
- Wall collision detection with crash latching, plus optional head-on detection.
- Sits between the keyboard decoder (which emits turn requests) and the trail RAM / sprite renderer (which consume positions, cells and direction).

Parameters:
- NUM_BIKES, 2, number of bike channels (1..4).
- POS_W, 10, pixel coordinate width.
- CELL_LOG2, 2, log2 of grid cell size in pixels (cell = 4 px).
- STEP, 1, pixels moved per frame tick; must divide 2**CELL_LOG2.
- X_MIN/X_MAX, 14/462, inclusive legal X range.
- Y_MIN/Y_MAX, 14/462, inclusive legal Y range.
- SPAWN_X0, 76, X spawn of bike 0.
- SPAWN_DX, 324, X spawn spacing; bike i spawns at SPAWN_X0 + i*SPAWN_DX.
- SPAWN_Y, 240, Y spawn of all bikes.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  frame strobe (~60 Hz), asynchronous-level, edge-detected internally.
- Game_State  in  3  3'b001 = spawn, 3'b010 = run, other = hold.
- turn_req  in  NUM_BIKES  per-bike one-cycle turn request strobe.
- turn_dir  in  2*NUM_BIKES  requested dir_t per bike, valid with turn_req.
- bike_x_real, bike_y_real  out  POS_W*NUM_BIKES  pixel positions.
- bike_x_cell, bike_y_cell  out  (POS_W-CELL_LOG2)*NUM_BIKES  cell positions (pixel >> CELL_LOG2).
- bike_dir  out  2*NUM_BIKES  current dir_t.
- crashed  out  NUM_BIKES  latched crash flag.
- step_pulse  out  1  high for one Clk when positions update.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (Clk, Reset).
- Reset or Game_State==001 (spawn): every bike at spawn. Even i faces RIGHT, odd i faces LEFT. crashed=0, pending cleared, step_pulse=0, FSM=SPAWN.
- Edge detect: frame_clk_d <= frame_clk; tick <= frame_clk & ~frame_clk_d. Positions change on the Clk edge after tick is high, i.e. 2 Clk after the frame_clk rise. step_pulse coincides with the register update.
- Per-bike FSM:
  - SPAWN -> RUN when Game_State==010.
  - RUN -> CRASHED on collision.
  - CRASHED holds until Reset or spawn.
  - Any state -> SPAWN on Reset or spawn.
  - Game_State "hold": all registers frozen, ticks ignored, turn requests still buffered.
- Turn buffer (one entry):
  - A turn_req with dir == opposite(current dir) or == current dir is dropped.
  - Otherwise dir is stored in pending; a newer request overwrites it.
  - A request arriving in the same cycle as a tick is not used by that tick.
- On a tick in RUN:
  - aligned = x and y both multiples of 2**CELL_LOG2.
  - If pending valid and aligned: dir <= pending, pending cleared, and the move uses the new dir in the same tick.
  - Otherwise move in the current dir.
- Arithmetic: next position is computed in POS_W+1 signed, so underflow below 0 is detected.
- Wall collision: if next X < X_MIN, X > X_MAX, Y < Y_MIN or Y > Y_MAX, the position is not updated and crashed <= 1.
- CRASHED bikes never move and ignore turn_req.
- Reset mid-run overrides everything in the same cycle.

Optional Feature:
- Macro: BIKE_HEADON_EN.
- Defined: after the move, every pair of RUN bikes whose next cells are equal both crash. Their moves are committed, and a pending turn still applies.
- Undefined: only wall collisions; bikes may share a cell.

Decomposition:
- Package bike_pkg:
  - dir_t enum {UP=0, DOWN=1, LEFT=2, RIGHT=3}.
  - GS_SPAWN = 3'b001, GS_RUN = 3'b010.
  - function opposite(dir_t).
  - bike FSM state enum.
- Sub-module bike_channel (one per bike, generate loop): FSM, pending buffer, position/dir registers, wall check.
- Top level holds: edge detect, step_pulse, head-on comparator, output packing.

Test Plan:
1. Reset, then GS_RUN, one frame_clk rise -> after 2 Clk: bike0 (77,240) RIGHT, bike1 (399,240) LEFT, step_pulse one cycle.
2. bike0 at x=77, turn_req UP -> pending. Ticks move x to 78, 79, 80. On the next tick: dir=UP, position (80,239).
3. bike0 RIGHT, turn_req LEFT -> dropped. Next tick x+1, dir stays RIGHT. A following turn_req DOWN at an aligned position is applied.
4. bike0 runs RIGHT from 76 -> reaches x=462 after 386 ticks. Tick 387 -> crashed=1, x stays 462. Further ticks and turns have no effect.
5. With BIKE_HEADON_EN, both bikes straight: tick 161 -> x=237/239 (cell 59) and both crashed. Without the macro, both keep moving.
6. Assert Reset mid-run, then pulse Game_State=001 at tick 50 -> spawn positions, crashed=0, pending cleared. Game_State=000 during frame_clk -> no movement.
